// File: rtl/sr_bank_pkg.sv
// Shared mode encodings and widths for the SR/JK/D/T register bank.
package sr_bank_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SR = 2'd0,
        MODE_JK = 2'd1,
        MODE_D  = 2'd2,
        MODE_T  = 2'd3
    } mode_e;

endpackage

// File: rtl/sr_cell.sv
// Combinational next-state logic for one flip-flop channel in any of the four modes.
module sr_cell
    import sr_bank_pkg::*;
(
    input  mode_e mode,
    input  logic  s,
    input  logic  r,
    input  logic  q,
    output logic  q_next,
    output logic  illegal
);

    always_comb begin
        q_next  = q;
        illegal = 1'b0;
        unique case (mode)
            MODE_SR: begin
                unique case ({s, r})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   illegal = 1'b1;  // forbidden combination: hold and report
                    default: q_next = q;
                endcase
            end
            MODE_JK: begin
                unique case ({s, r})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_D:  q_next = s;
            MODE_T:  q_next = s ? ~q : q;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH mode-selectable flip-flops with sticky illegal-input flags and a
// saturating count of cycles in which any channel saw S=R=1 in SR mode.
module sr_reg_bank
    import sr_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [MODE_W-1:0]      mode,
    input  logic [WIDTH-1:0]       S,
    input  logic [WIDTH-1:0]       R,
    input  logic                   clr_ill,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH-1:0]       Q_bar,
    output logic [WIDTH-1:0]       ill,
    output logic [CNT_W-1:0]       ill_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    mode_e              mode_sel;
    logic [WIDTH-1:0]   q_next;
    logic [WIDTH-1:0]   illegal;
    logic [WIDTH-1:0]   ill_next;
    logic [CNT_W-1:0]   cnt_next;

    assign mode_sel = mode_e'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell u_cell (
            .mode    (mode_sel),
            .s       (S[i]),
            .r       (R[i]),
            .q       (Q[i]),
            .q_next  (q_next[i]),
            .illegal (illegal[i])
        );
    end

    // Clear and new events in the same cycle: the new event survives.
    always_comb begin
        ill_next = clr_ill ? '0 : ill;
        cnt_next = ill_cnt;
        if (en) begin
            ill_next = ill_next | illegal;
            if ((|illegal) && (ill_cnt != CNT_MAX)) begin
                cnt_next = ill_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Q       <= '0;
            ill     <= '0;
            ill_cnt <= '0;
        end else begin
            if (en) begin
                Q <= q_next;
            end
            ill     <= ill_next;
            ill_cnt <= cnt_next;
        end
    end

    // Derived directly from Q so it never lags the state register.
    assign Q_bar = ~Q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Self-checking bench for sr_reg_bank: directed scenarios plus randomized traffic
// compared against a per-bit behavioural model; a CNT_W=2 instance shares the inputs.
module tb_sr_reg_bank;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] S = '0;
    logic [W-1:0] R = '0;
    logic         clr_ill = 1'b0;

    logic [W-1:0] Q, Q_bar, ill, Q2, Q_bar2, ill2;
    logic [7:0]   ill_cnt;
    logic [1:0]   ill_cnt2;

    int compares = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_ill = '0;
    int           m_cnt = 0;
    int           m_cnt2 = 0;

    always #5 clk = ~clk;

    sr_reg_bank #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .S(S), .R(R), .clr_ill(clr_ill),
        .Q(Q), .Q_bar(Q_bar), .ill(ill), .ill_cnt(ill_cnt)
    );

    sr_reg_bank #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .S(S), .R(R), .clr_ill(clr_ill),
        .Q(Q2), .Q_bar(Q_bar2), .ill(ill2), .ill_cnt(ill_cnt2)
    );

    wire [35:0] act = {Q, Q_bar, ill, ill_cnt, Q2, Q_bar2, ill2, ill_cnt2};

    function automatic logic [35:0] expv();
        return {m_q, ~m_q, m_ill, 8'(m_cnt), m_q, ~m_q, m_ill, 2'(m_cnt2)};
    endfunction

    // Model of one clock edge, written straight from the per-mode truth tables.
    task automatic model_edge();
        logic [W-1:0] nq;
        logic [W-1:0] bad;
        nq  = m_q;
        bad = '0;
        if (rst) begin
            m_q = '0; m_ill = '0; m_cnt = 0; m_cnt2 = 0;
            return;
        end
        if (clr_ill) m_ill = '0;
        if (en) begin
            for (int i = 0; i < W; i++) begin
                case (mode)
                    2'd0: if (S[i] && R[i]) bad[i] = 1'b1;
                          else if (S[i]) nq[i] = 1'b1;
                          else if (R[i]) nq[i] = 1'b0;
                    2'd1: if (S[i] && R[i]) nq[i] = ~m_q[i];
                          else if (S[i]) nq[i] = 1'b1;
                          else if (R[i]) nq[i] = 1'b0;
                    2'd2: nq[i] = S[i];
                    default: if (S[i]) nq[i] = ~m_q[i];
                endcase
            end
            m_q   = nq;
            m_ill = m_ill | bad;
            if (bad != 0) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    task automatic step(input logic e, input logic [1:0] md, input logic [W-1:0] s,
                        input logic [W-1:0] r, input logic clr, input logic rs);
        en = e; mode = md; S = s; R = r; clr_ill = clr; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) step(1'b1, 2'd1, 4'hF, 4'hF, 1'b0, 1'b1);
        compares++;
        if ({Q, Q_bar, ill, ill_cnt, ill_cnt2} !== {4'h0, 4'hF, 4'h0, 8'd0, 2'd0}) begin
            fails++;
            $display("FAIL reset: got Q=%b Q_bar=%b ill=%b cnt=%0d cnt2=%0d, want 0000 1111 0000 0 0",
                     Q, Q_bar, ill, ill_cnt, ill_cnt2);
        end
    endtask

    task automatic test_sr();
        logic [W-1:0] want [2] = '{4'b0101, 4'b0001};
        step(1'b1, 2'd0, 4'b0101, 4'b0000, 1'b0, 1'b0);
        compares++;
        if (Q !== want[0] || ill !== 4'b0000) begin
            fails++; $display("FAIL sr_set: got Q=%b ill=%b, want Q=%b ill=0000", Q, ill, want[0]);
        end
        step(1'b1, 2'd0, 4'b0000, 4'b0100, 1'b0, 1'b0);
        compares++;
        if (Q !== want[1] || ill !== 4'b0000 || act !== expv()) begin
            fails++; $display("FAIL sr_reset: got Q=%b ill=%b, want Q=%b ill=0000", Q, ill, want[1]);
        end
    endtask

    task automatic test_illegal();
        step(1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        step(1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'd0, 4'b1001, 4'b1000, 1'b0, 1'b0);
            compares++;
            if (act !== expv()) begin
                fails++; $display("FAIL illegal_cycle%0d: got %h, want %h", k, act, expv());
            end
        end
        compares++;
        if (Q !== 4'b0001 || ill !== 4'b1000 || ill_cnt !== 8'd3) begin
            fails++; $display("FAIL illegal_hold: got Q=%b ill=%b cnt=%0d, want 0001 1000 3", Q, ill, ill_cnt);
        end
        step(1'b1, 2'd0, 4'b1001, 4'b1000, 1'b1, 1'b0);
        compares++;
        if (ill !== 4'b1000 || ill_cnt !== 8'd4 || ill_cnt2 !== 2'd3) begin
            fails++; $display("FAIL clr_vs_set: got ill=%b cnt=%0d cnt2=%0d, want 1000 4 3", ill, ill_cnt, ill_cnt2);
        end
        step(1'b1, 2'd2, 4'b0000, 4'b0000, 1'b1, 1'b0);
        compares++;
        if (ill !== 4'b0000 || ill_cnt !== 8'd4) begin
            fails++; $display("FAIL clr_only: got ill=%b cnt=%0d, want 0000 4", ill, ill_cnt);
        end
    endtask

    task automatic test_modes();
        logic [7:0] c0;
        step(1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0, 1'b0);
        c0 = ill_cnt;
        step(1'b1, 2'd1, 4'b1111, 4'b1111, 1'b0, 1'b0);
        compares++;
        if (Q !== 4'b1111) begin fails++; $display("FAIL jk_toggle1: got %b, want 1111", Q); end
        step(1'b1, 2'd1, 4'b1111, 4'b1111, 1'b0, 1'b0);
        compares++;
        if (Q !== 4'b0000) begin fails++; $display("FAIL jk_toggle2: got %b, want 0000", Q); end
        step(1'b1, 2'd3, 4'b0011, 4'b1111, 1'b0, 1'b0);
        compares++;
        if (Q !== 4'b0011) begin fails++; $display("FAIL t_mode: got %b, want 0011", Q); end
        step(1'b1, 2'd2, 4'b1010, 4'b1111, 1'b0, 1'b0);
        compares++;
        if (Q !== 4'b1010 || ill_cnt !== c0 || ill !== 4'b0000) begin
            fails++; $display("FAIL d_mode: got Q=%b cnt=%0d ill=%b, want 1010 %0d 0000", Q, ill_cnt, ill, c0);
        end
    endtask

    task automatic test_saturate_en();
        logic [1:0] want2 [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        logic [35:0] held;
        step(1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 2'd0, 4'b0110, 4'b0111, 1'b0, 1'b0);
            compares++;
            if (ill_cnt2 !== want2[k] || act !== expv()) begin
                fails++; $display("FAIL sat2_cycle%0d: got cnt2=%0d all=%h, want cnt2=%0d all=%h",
                                  k, ill_cnt2, act, want2[k], expv());
            end
        end
        held = act;
        for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 4'b0110, 4'b0111, 1'b0, 1'b0);
        compares++;
        if (act !== held || act !== expv()) begin
            fails++; $display("FAIL en_hold: got %h, want %h", act, held);
        end
        for (int k = 0; k < 260; k++) step(1'b1, 2'd0, 4'b1111, 4'b1111, 1'b0, 1'b0);
        compares++;
        if (ill_cnt !== 8'd255 || ill !== 4'b1111) begin
            fails++; $display("FAIL sat8: got cnt=%0d ill=%b, want 255 1111", ill_cnt, ill);
        end
        step(1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 1'b0);
        compares++;
        if (ill !== 4'b0000 || ill_cnt !== 8'd255) begin
            fails++; $display("FAIL clr_en0: got ill=%b cnt=%0d, want 0000 255", ill, ill_cnt);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 2'd0, 4'b1000, 4'b1000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'd1, 4'b1111, 4'b1111, 1'b0, 1'b0);
            compares++;
            if (Q_bar !== ~m_q || act !== expv()) begin
                fails++; $display("FAIL jk_pre_rst%0d: got %h, want %h", k, act, expv());
            end
        end
        step(1'b1, 2'd1, 4'b1111, 4'b1111, 1'b1, 1'b1);
        compares++;
        if ({Q, Q_bar, ill, ill_cnt} !== {4'h0, 4'hF, 4'h0, 8'd0}) begin
            fails++; $display("FAIL rst_mid: got Q=%b Q_bar=%b ill=%b cnt=%0d, want 0000 1111 0000 0",
                              Q, Q_bar, ill, ill_cnt);
        end
        step(1'b1, 2'd1, 4'b1111, 4'b1111, 1'b0, 1'b0);
        compares++;
        if (Q !== 4'b1111 || Q_bar !== 4'b0000) begin
            fails++; $display("FAIL first_after_rst: got Q=%b Q_bar=%b, want 1111 0000", Q, Q_bar);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
                 4'($urandom), ($urandom_range(0, 11) == 0), ($urandom_range(0, 99) == 0));
            compares++;
            if (act !== expv()) begin
                fails++; bad++;
                if (bad <= 10) $display("FAIL random%0d: got %h, want %h", k, act, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sr();
        test_illegal();
        test_modes();
        test_saturate_en();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule

// File: doc/sr_reg_bank.md
SR_REG_BANK -- requirements
Module: sr_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, 4, number of independent flip-flop channels (1..32).
REQ-002 SHALL have parameter CNT_W, 8, width of the illegal-event counter (2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  update enable; en=0 holds all state.
REQ-006 SHALL have port mode  input  2  0=SR, 1=JK, 2=D, 3=T; applies to all channels in the same cycle.
REQ-007 SHALL have port S  input  WIDTH  per-channel set / J / D / T input.
REQ-008 SHALL have port R  input  WIDTH  per-channel reset / K input; ignored in D and T modes.
REQ-009 SHALL have port clr_ill  input  1  clears the ill sticky flags.
REQ-010 SHALL have port Q  output  WIDTH  registered channel state.
REQ-011 SHALL have port Q_bar  output  WIDTH  bitwise complement of Q, always ~Q.
REQ-012 SHALL have port ill  output  WIDTH  per-channel sticky flag: S=R=1 seen in SR mode.
REQ-013 SHALL have port ill_cnt  output  CNT_W  saturating count of cycles with any illegal channel.

Function
REQ-014 Q SHALL update only on rising clk with en=1 and rst=0; latency 1 cycle from inputs to Q.
REQ-015 SR mode per bit: S=0,R=0 hold; S=0,R=1 Q<=0; S=1,R=0 Q<=1; S=1,R=1 hold and flag illegal.
REQ-016 JK mode per bit: 00 hold; 01 Q<=0; 10 Q<=1; 11 Q<=~Q; never flags illegal.
REQ-017 D mode per bit: Q<=S.
REQ-018 T mode per bit: S=1 Q<=~Q; S=0 hold.
REQ-019 Q_bar SHALL equal ~Q in every cycle, including reset, with no extra register lag.
REQ-020 ill[i] SHALL set on the edge where en=1, mode=SR, S[i]=R[i]=1, and stay set until clr_ill or rst.
REQ-021 clr_ill=1 SHALL clear all ill bits on the next edge, independent of en.
REQ-022 Simultaneous clr_ill and new illegal event on bit i: ill[i] SHALL be 1 after the edge (set wins).
REQ-023 ill_cnt SHALL increment by 1 per edge with en=1, mode=SR, and any bit illegal (not per bit).
REQ-024 ill_cnt SHALL saturate at 2^CNT_W-1 and never wrap; clr_ill SHALL NOT clear ill_cnt.
REQ-025 mode change SHALL take effect on the same edge it is sampled; no pipeline of mode.
REQ-026 en=0 SHALL suppress Q, ill set, and ill_cnt increment; clr_ill still acts.

Reset
REQ-027 rst=1 at an edge SHALL force Q=0, Q_bar=all ones, ill=0, ill_cnt=0, overriding en, mode, clr_ill.
REQ-028 Reset asserted mid-operation SHALL take effect on the next edge with no residual state; first update occurs on first edge with rst=0.

Structure
REQ-029 Mode encodings (MODE_SR, MODE_JK, MODE_D, MODE_T) SHALL live in shared package sr_bank_pkg.
REQ-030 Per-bit next-state logic SHALL be a combinational sub-module sr_cell (inputs mode, s, r, q; outputs q_next, illegal), instantiated WIDTH times by generate.
REQ-031 Counter and sticky flags SHALL reside in the top level, not in sr_cell.

Verification
REQ-032 WIDTH=4: rst 2 cycles -> Q=0000, Q_bar=1111, ill=0000, ill_cnt=0.
REQ-033 SR, en=1, S=0101,R=0000 then S=0000,R=0100 -> Q=0101 then Q=0001; ill stays 0000.
REQ-034 SR, Q=0001, S=1001,R=1000 for 3 cycles -> Q=0001 held, ill=1000, ill_cnt=3; then clr_ill with same stimulus -> ill=1000, ill_cnt=4.
REQ-035 JK S=R=1111 from Q=0000 for 2 cycles -> Q=1111 then 0000; T S=0011 from 0000 -> 0011; D S=1010 -> 1010; ill_cnt unchanged.
REQ-036 CNT_W=2, SR illegal 6 cycles -> ill_cnt 1,2,3,3,3,3; en=0 same stimulus -> Q, ill, ill_cnt unchanged.
REQ-037 rst=1 asserted mid-JK toggling with clr_ill=1,en=1 -> next edge Q=0000, ill=0000, ill_cnt=0; Q_bar==~Q checked every cycle.
